axi_mm_burst_to_axis: RTL and testbench

AXI4 read master that fetches NUM_BEATS data beats starting at BASE_ADDR using INCR bursts and emits them as an AXI Stream with TLAST on the final beat. It is the read-back counterpart of the stream-to-memory burst writer, and sits downstream of memory, feeding stream consumers such as checkers and video sinks. A top-level FSM drives it with a START/DONE pair, in the same way the writer is driven. Each burst is issued only when an internal FIFO has room for the whole burst, so RREADY is never back-pressured.

---
 rtl/axi_mm_pkg.sv | 30 +++
 rtl/axis_sync_fifo.sv | 63 ++++++
 rtl/axi_mm_burst_to_axis.sv | 183 ++++++++++++++++++
 tb/tb_axi_mm_burst_to_axis.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mm_pkg.sv
// Shared AXI memory-mapped definitions for the burst reader: protocol
// encodings, the 4 KB page size and the reader state type.
package axi_mm_pkg;

   localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
   localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
   localparam logic [12:0] AXI_4K_BYTES   = 13'h1000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_SPACE,
      ST_ADDR,
      ST_DATA,
      ST_DRAIN,
      ST_FINISH
   } rd_state_t;

   // AxSIZE encoding for a full-width beat of the given data width
   function automatic logic [2:0] axi_size_enc(input int data_w);
      case (data_w)
         8:       return 3'd0;
         16:      return 3'd1;
         32:      return 3'd2;
         64:      return 3'd3;
         128:     return 3'd4;
         default: return 3'd2;
      endcase
   endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with occupancy count. Storage is not reset; only the
// pointers and count are, so a reset flushes the contents.
module axis_sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 32
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           push_i,
   input  logic [WIDTH-1:0]               din_i,
   input  logic                           pop_i,
   output logic [WIDTH-1:0]               dout_o,
   output logic [$clog2(DEPTH+1)-1:0]     count_o,
   output logic                           empty_o,
   output logic                           full_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             pop_ok;

   assign pop_ok  = pop_i && !empty_o;
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Pointer wrap and occupancy update; push and pop together leave count unchanged
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_i) wr_ptr_d = (wr_ptr_q == AW'(DEPTH-1)) ? '0 : wr_ptr_q + AW'(1);
      if (pop_ok) rd_ptr_d = (rd_ptr_q == AW'(DEPTH-1)) ? '0 : rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_ok);
   end

   // Control state with asynchronous flush
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Data storage write
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= din_i;
   end

   // Writers only push when space was reserved, so a push into a full FIFO is a bug
   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
                                   !(push_i && full_o && !pop_i));

endmodule

// File: rtl/axi_mm_burst_to_axis.sv
// AXI4 read master: fetches NUM_BEATS beats from BASE_ADDR with INCR bursts
// that never cross 4 KB, and replays them as an AXI Stream with TLAST on the
// final beat. A burst is only requested once the FIFO can absorb all of it,
// so RREADY stays high for the whole data phase.
module axi_mm_burst_to_axis
   import axi_mm_pkg::*;
#(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int MAX_BURST_LEN  = 16,
   parameter int FIFO_DEPTH     = 32
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR,
   input  logic [31:0]               NUM_BEATS,
   input  logic                      START,
   output logic                      BUSY,
   output logic                      DONE,
   output logic                      ERROR,
   output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]                m_axi_arlen,
   output logic [2:0]                m_axi_arsize,
   output logic [1:0]                m_axi_arburst,
   output logic [2:0]                m_axi_arprot,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rlast,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready,
   output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
   output logic                      m_axis_tlast,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready
);

   localparam int BPB = AXI_DATA_WIDTH / 8;
   localparam int SZ  = $clog2(BPB);
   localparam int CW  = $clog2(FIFO_DEPTH+1);
   localparam logic [2:0] SIZE_ENC = axi_size_enc(AXI_DATA_WIDTH);
   localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK = ~AXI_ADDR_WIDTH'(BPB-1);

   rd_state_t                 state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]               remain_q, remain_d, total_q, total_d, beat_q, beat_d;
   logic [7:0]                arlen_q, arlen_d, bcnt_q, bcnt_d;
   logic                      err_q, err_d;

   logic [CW-1:0]             fifo_count;
   logic                      fifo_empty, fifo_full;
   logic [AXI_DATA_WIDTH:0]   fifo_dout;
   logic [12:0]               to4k_bytes;
   logic [31:0]               to4k_beats, len_c, room_c, len_ar;
   logic                      ar_hs, r_hs, pop, burst_last, beat_tlast, space_ok;

   assign ar_hs      = m_axi_arvalid && m_axi_arready;
   assign r_hs       = m_axi_rvalid && m_axi_rready;
   assign pop        = !fifo_empty && m_axis_tready;
   assign burst_last = (bcnt_q == arlen_q);
   assign beat_tlast = ((beat_q + 32'd1) == total_q);
   assign len_ar     = 32'(arlen_q) + 32'd1;
   assign to4k_bytes = AXI_4K_BYTES - {1'b0, addr_q[11:0]};
   assign to4k_beats = 32'(to4k_bytes) >> SZ;
   assign room_c     = 32'(FIFO_DEPTH) - 32'(fifo_count);
   assign space_ok   = !fifo_full && (room_c >= len_c);

   // Next burst length: limited by max burst, beats left and the 4 KB page end
   always_comb begin
      len_c = remain_q;
      if (len_c > 32'(MAX_BURST_LEN)) len_c = 32'(MAX_BURST_LEN);
      if (len_c > to4k_beats)         len_c = to4k_beats;
   end

   // FSM state register
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state; burst end follows the beat count, not RLAST
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:       if (START) state_d = (NUM_BEATS == 32'd0) ? ST_FINISH : ST_WAIT_SPACE;
         ST_WAIT_SPACE: if (space_ok) state_d = ST_ADDR;
         ST_ADDR:       if (ar_hs) state_d = ST_DATA;
         ST_DATA:       if (r_hs && burst_last) state_d = (remain_q != 32'd0) ? ST_WAIT_SPACE : ST_DRAIN;
         ST_DRAIN:      if (pop && fifo_dout[AXI_DATA_WIDTH]) state_d = ST_FINISH;
         ST_FINISH:     state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
   end

   // FSM outputs decoded from the current state
   always_comb begin
      BUSY          = (state_q != ST_IDLE);
      DONE          = (state_q == ST_FINISH);
      m_axi_arvalid = (state_q == ST_ADDR);
      m_axi_rready  = (state_q == ST_DATA);
   end

   // Transfer bookkeeping: address, counts, burst length and sticky error
   always_comb begin
      addr_d   = addr_q;
      remain_d = remain_q;
      total_d  = total_q;
      beat_d   = beat_q;
      arlen_d  = arlen_q;
      bcnt_d   = bcnt_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: if (START) begin
            addr_d   = BASE_ADDR & ADDR_MASK;
            remain_d = NUM_BEATS;
            total_d  = NUM_BEATS;
            beat_d   = 32'd0;
            err_d    = 1'b0;
         end
         ST_WAIT_SPACE: if (space_ok) arlen_d = 8'(len_c - 32'd1);
         ST_ADDR: if (ar_hs) begin
            addr_d   = addr_q + (AXI_ADDR_WIDTH'(len_ar) << SZ);
            remain_d = remain_q - len_ar;
            bcnt_d   = 8'd0;
         end
         ST_DATA: if (r_hs) begin
            bcnt_d = bcnt_q + 8'd1;
            beat_d = beat_q + 32'd1;
            if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != burst_last)) err_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Bookkeeping registers
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         addr_q   <= '0;
         remain_q <= '0;
         total_q  <= '0;
         beat_q   <= '0;
         arlen_q  <= '0;
         bcnt_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         addr_q   <= addr_d;
         remain_q <= remain_d;
         total_q  <= total_d;
         beat_q   <= beat_d;
         arlen_q  <= arlen_d;
         bcnt_q   <= bcnt_d;
         err_q    <= err_d;
      end
   end

   assign ERROR         = err_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = arlen_q;
   assign m_axi_arsize  = SIZE_ENC;
   assign m_axi_arburst = AXI_BURST_INCR;
   assign m_axi_arprot  = 3'b000;

   assign m_axis_tvalid = !fifo_empty;
   assign m_axis_tdata  = fifo_dout[AXI_DATA_WIDTH-1:0];
   assign m_axis_tlast  = fifo_dout[AXI_DATA_WIDTH];

   axis_sync_fifo #(
      .WIDTH(AXI_DATA_WIDTH + 1),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk_i  (ACLK),
      .rst_i  (ARESET),
      .push_i (r_hs),
      .din_i  ({beat_tlast, m_axi_rdata}),
      .pop_i  (pop),
      .dout_o (fifo_dout),
      .count_o(fifo_count),
      .empty_o(fifo_empty),
      .full_o (fifo_full)
   );

endmodule

// File: tb/tb_axi_mm_burst_to_axis.sv
// Directed bench for axi_mm_burst_to_axis: a small AXI read slave returns
// word index (addr - mem_base)/4 as data, a stream sink records accepted beats.
module tb_axi_mm_burst_to_axis;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic [31:0] BASE_ADDR = '0;
   logic [31:0] NUM_BEATS = '0;
   logic        START = 1'b0;
   logic        BUSY, DONE, ERROR;
   logic [31:0] m_axi_araddr;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize;
   logic [1:0]  m_axi_arburst;
   logic [2:0]  m_axi_arprot;
   logic        m_axi_arvalid;
   logic        m_axi_arready = 1'b0;
   logic [31:0] m_axi_rdata = '0;
   logic [1:0]  m_axi_rresp = 2'b00;
   logic        m_axi_rlast = 1'b0;
   logic        m_axi_rvalid = 1'b0;
   logic        m_axi_rready;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tlast;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;

   always #5 ACLK = ~ACLK;

   axi_mm_burst_to_axis dut (
      .ACLK(ACLK), .ARESET(ARESET), .BASE_ADDR(BASE_ADDR), .NUM_BEATS(NUM_BEATS),
      .START(START), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
      .m_axi_arburst(m_axi_arburst), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
   );

   int total = 0;
   int bad   = 0;

   // bench knobs
   logic [31:0] mem_base = '0;
   logic [31:0] err_word = 32'hFFFF_FFFF;
   int          ar_dly_max = 0;
   int          tr_mode = 0;   // 0: always ready, 1: 30% stalls, 2: never ready

   // observation logs
   int          ar_n = 0;
   logic [31:0] ar_addr_log [16];
   logic [7:0]  ar_len_log  [16];
   int          got_n = 0;
   logic [31:0] got_d [128];
   logic        got_l [128];
   int          stall_err = 0, rready_drop = 0, done_cnt = 0, arv_cnt = 0;

   // slave state
   logic        in_burst = 1'b0;
   logic [31:0] r_addr = '0;
   int          r_left = 0, ar_cnt = 0, ar_dly = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // AXI read slave: one burst at a time, random AR delay, SLVERR on err_word
   always begin : slave
      logic        arf, rf;
      logic [31:0] cap_addr;
      logic [7:0]  cap_len;
      @(negedge ACLK);
      arf = m_axi_arvalid && m_axi_arready;
      rf  = m_axi_rvalid && m_axi_rready;
      cap_addr = m_axi_araddr;
      cap_len  = m_axi_arlen;
      if (in_burst && !m_axi_rready && !ARESET) rready_drop++;
      if (m_axi_arvalid) arv_cnt++;
      @(posedge ACLK); #1;
      if (ARESET) begin
         in_burst = 1'b0; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; ar_cnt = 0;
      end else begin
         if (arf) begin
            if (ar_n < 16) begin ar_addr_log[ar_n] = cap_addr; ar_len_log[ar_n] = cap_len; end
            ar_n++;
            in_burst = 1'b1; r_addr = cap_addr; r_left = int'(cap_len) + 1;
            m_axi_arready = 1'b0; ar_cnt = 0;
            ar_dly = int'($urandom_range(0, ar_dly_max));
         end else if (m_axi_arvalid && !m_axi_arready) begin
            if (ar_cnt >= ar_dly) m_axi_arready = 1'b1;
            else ar_cnt++;
         end
         if (rf) begin
            r_addr = r_addr + 32'd4;
            r_left--;
            if (r_left == 0) in_burst = 1'b0;
         end
         m_axi_rvalid = in_burst;
         m_axi_rdata  = (r_addr - mem_base) >> 2;
         m_axi_rlast  = (r_left == 1);
         m_axi_rresp  = (((r_addr - mem_base) >> 2) == err_word) ? 2'b10 : 2'b00;
      end
   end

   // stream sink ready pattern
   always begin : sink
      @(posedge ACLK); #1;
      case (tr_mode)
         0:       m_axis_tready = 1'b1;
         1:       m_axis_tready = ($urandom_range(0, 99) >= 30);
         default: m_axis_tready = 1'b0;
      endcase
   end

   // stream monitor: records accepted beats, stall stability, DONE pulses
   always begin : mon
      logic        prev_stall;
      logic [31:0] prev_d;
      logic        prev_l;
      @(negedge ACLK);
      if (ARESET) prev_stall = 1'b0;
      else begin
         if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l))
            stall_err++;
         if (m_axis_tvalid && m_axis_tready) begin
            if (got_n < 128) begin got_d[got_n] = m_axis_tdata; got_l[got_n] = m_axis_tlast; end
            got_n++;
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_d     = m_axis_tdata;
         prev_l     = m_axis_tlast;
         if (DONE) done_cnt++;
      end
   end

   task automatic clr_logs();
      ar_n = 0; got_n = 0; done_cnt = 0; stall_err = 0; rready_drop = 0; arv_cnt = 0;
   endtask

   task automatic start_xfer(input logic [31:0] base, input logic [31:0] n);
      @(posedge ACLK); #1;
      BASE_ADDR = base; NUM_BEATS = n; START = 1'b1;
      @(posedge ACLK); #1;
      START = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int lat, output logic seen);
      lat = 0; seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge ACLK);
         if (DONE) begin seen = 1'b1; lat = i; break; end
      end
   endtask

   task automatic check_stream(input string tag, input int n);
      int errs;
      errs = 0;
      for (int i = 0; i < n && i < 128; i++) begin
         if (got_d[i] !== 32'(i)) errs++;
         if (got_l[i] !== (i == n - 1)) errs++;
      end
      chk({tag, "_beats"}, 64'(got_n), 64'(n));
      chk({tag, "_data_last"}, 64'(errs), 64'd0);
   endtask

   initial begin : main
      int   lat;
      logic seen;

      // reset state
      repeat (3) @(negedge ACLK);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_done", DONE, 1'b0);
      chk("rst_error", ERROR, 1'b0);
      chk("rst_arvalid", m_axi_arvalid, 1'b0);
      chk("rst_rready", m_axi_rready, 1'b0);
      chk("rst_tvalid", m_axis_tvalid, 1'b0);
      chk("rst_araddr", m_axi_araddr, 32'h0);
      chk("rst_arlen", m_axi_arlen, 8'h0);
      chk("arsize", m_axi_arsize, 3'd2);
      chk("arburst", m_axi_arburst, 2'b01);
      chk("arprot", m_axi_arprot, 3'b000);
      @(posedge ACLK); #1;
      ARESET = 1'b0;

      // basic: 40 beats from 0x1000
      clr_logs(); mem_base = 32'h1000;
      start_xfer(32'h1000, 32'd40);
      chk("basic_busy", BUSY, 1'b1);
      wait_done(2000, lat, seen);
      chk("basic_done_seen", seen, 1'b1);
      chk("basic_busy_at_done", BUSY, 1'b1);
      @(posedge ACLK); #2;
      chk("basic_done_pulse", DONE, 1'b0);
      chk("basic_busy_after", BUSY, 1'b0);
      chk("basic_ar_n", 64'(ar_n), 64'd3);
      chk("basic_ar0_addr", ar_addr_log[0], 32'h1000);
      chk("basic_ar0_len", ar_len_log[0], 8'd15);
      chk("basic_ar1_addr", ar_addr_log[1], 32'h1040);
      chk("basic_ar1_len", ar_len_log[1], 8'd15);
      chk("basic_ar2_addr", ar_addr_log[2], 32'h1080);
      chk("basic_ar2_len", ar_len_log[2], 8'd7);
      check_stream("basic", 40);
      chk("basic_done_cnt", 64'(done_cnt), 64'd1);
      chk("basic_error", ERROR, 1'b0);

      // 4 KB split
      clr_logs(); mem_base = 32'h0FF8;
      start_xfer(32'h0FF8, 32'd8);
      wait_done(500, lat, seen);
      chk("split_done_seen", seen, 1'b1);
      @(posedge ACLK); #2;
      chk("split_ar_n", 64'(ar_n), 64'd2);
      chk("split_ar0_addr", ar_addr_log[0], 32'h0FF8);
      chk("split_ar0_len", ar_len_log[0], 8'd1);
      chk("split_ar1_addr", ar_addr_log[1], 32'h1000);
      chk("split_ar1_len", ar_len_log[1], 8'd5);
      check_stream("split", 8);

      // back-pressure on both sides
      clr_logs(); mem_base = 32'h2000; tr_mode = 1; ar_dly_max = 5;
      start_xfer(32'h2000, 32'd100);
      wait_done(5000, lat, seen);
      chk("bp_done_seen", seen, 1'b1);
      @(posedge ACLK); #2;
      tr_mode = 0; ar_dly_max = 0;
      check_stream("bp", 100);
      chk("bp_ar_n", 64'(ar_n), 64'd7);
      chk("bp_stall_stable", 64'(stall_err), 64'd0);
      chk("bp_rready_drop", 64'(rready_drop), 64'd0);
      chk("bp_error", ERROR, 1'b0);

      // zero length: DONE right after the accepting edge, no AR traffic
      clr_logs();
      start_xfer(32'h0, 32'd0);
      wait_done(10, lat, seen);
      chk("zero_done_seen", seen, 1'b1);
      chk("zero_done_lat", 64'(lat), 64'd0);
      @(posedge ACLK); #2;
      @(posedge ACLK); #2;
      chk("zero_arvalid_cycles", 64'(arv_cnt), 64'd0);
      chk("zero_beats", 64'(got_n), 64'd0);
      chk("zero_done_cnt", 64'(done_cnt), 64'd1);

      // START while busy is ignored
      clr_logs(); mem_base = 32'h3000;
      start_xfer(32'h3000, 32'd20);
      repeat (3) @(posedge ACLK);
      start_xfer(32'h8000, 32'd3);
      wait_done(1000, lat, seen);
      chk("ign_done_seen", seen, 1'b1);
      @(posedge ACLK); #2;
      chk("ign_ar_n", 64'(ar_n), 64'd2);
      chk("ign_ar0_addr", ar_addr_log[0], 32'h3000);
      chk("ign_ar1_addr", ar_addr_log[1], 32'h3040);
      check_stream("ign", 20);
      chk("ign_done_cnt", 64'(done_cnt), 64'd1);

      // SLVERR on beat 5 of 20
      clr_logs(); mem_base = 32'h4000; err_word = 32'd5;
      start_xfer(32'h4000, 32'd20);
      wait_done(1000, lat, seen);
      chk("err_done_seen", seen, 1'b1);
      chk("err_at_done", ERROR, 1'b1);
      @(posedge ACLK); #2;
      chk("err_sticky", ERROR, 1'b1);
      check_stream("err", 20);
      err_word = 32'hFFFF_FFFF;
      clr_logs(); mem_base = 32'h4100;
      start_xfer(32'h4100, 32'd4);
      chk("err_cleared_on_start", ERROR, 1'b0);
      wait_done(500, lat, seen);
      chk("err2_done_seen", seen, 1'b1);
      @(posedge ACLK); #2;
      check_stream("err2", 4);
      chk("err2_error", ERROR, 1'b0);

      // reset in the middle of a data phase with beats sitting in the FIFO
      clr_logs(); mem_base = 32'h5000; tr_mode = 2;
      start_xfer(32'h5000, 32'd40);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge ACLK);
         if (m_axi_rready) begin seen = 1'b1; break; end
      end
      chk("rst_mid_reached_data", seen, 1'b1);
      repeat (3) @(negedge ACLK);
      chk("rst_mid_pre_tvalid", m_axis_tvalid, 1'b1);
      ARESET = 1'b1;
      #1;
      chk("rst_mid_busy", BUSY, 1'b0);
      chk("rst_mid_rready", m_axi_rready, 1'b0);
      chk("rst_mid_arvalid", m_axi_arvalid, 1'b0);
      chk("rst_mid_tvalid", m_axis_tvalid, 1'b0);
      chk("rst_mid_done", DONE, 1'b0);
      chk("rst_mid_error", ERROR, 1'b0);
      repeat (2) @(posedge ACLK);
      #1;
      ARESET = 1'b0; tr_mode = 0;
      @(posedge ACLK); #2;
      clr_logs(); mem_base = 32'h6000;
      start_xfer(32'h6000, 32'd4);
      wait_done(500, lat, seen);
      chk("post_rst_done_seen", seen, 1'b1);
      @(posedge ACLK); #2;
      chk("post_rst_ar_n", 64'(ar_n), 64'd1);
      chk("post_rst_ar0_addr", ar_addr_log[0], 32'h6000);
      chk("post_rst_ar0_len", ar_len_log[0], 8'd3);
      check_stream("post_rst", 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
